output_row_accumulator: RTL and testbench
=========================================

// Module: output_row_accumulator
// PURPOSE
//  Online-softmax output accumulator for one query row, sitting directly upstream of the vector divider.
//  Per accepted key step it rescales the running output vector and row-sum by the max-correction factor.
//  It then adds the p*V contribution. On the row's last key it presents (acc vector, row-sum l) as
//  (vec, divisor) for final normalisation.
// PARAMETERS
//  VEC_LEN    `MAX_EMBEDDING_DIM  elements per V / output vector
//  DATA_WIDTH `INTEGER_WIDTH      bit width of every data element, divisor, p and scale
//  FRAC_BITS  8                   fractional bits of p_in, scale_in (1.0 == 1<<FRAC_BITS)
// PORTS
//  clk          in   1                        clock; all state updates on posedge
//  rst          in   1                        synchronous, active-high reset
//  vld_in       in   1                        upstream key step valid
//  rdy_out      out  1                        this block can accept a key step
//  vld_out      out  1                        finished row result valid
//  rdy_in       in   1                        downstream (vector divider) ready
//  v_vec_in     in   DATA_WIDTH x VEC_LEN     signed V row for this key
//  p_in         in   DATA_WIDTH               unsigned exp(s - m_new), Q.FRAC_BITS
//  scale_in     in   DATA_WIDTH               unsigned exp(m_old - m_new), Q.FRAC_BITS; ignored on first key
//  last_in      in   1                        this key step is the last of the row
//  vec_out      out  DATA_WIDTH x VEC_LEN     signed accumulated output vector
//  divisor_out  out  DATA_WIDTH               unsigned row-sum l
//  sat_out      out  1                        any saturation occurred in this row (valid with vld_out)
// BEHAVIOUR
//  - Reset: state=ACCUM, first=1, acc[*]=0, l=0, vld_out=0, vec_out=0, divisor_out=0, sat_out=0.
//  - Reset has priority over every other event. A reset mid-row or in DRAIN discards all partial and
//    pending results.
//  - FSM, 2 states:
//    ACCUM: rdy_out=1, vld_out=0. Accept when vld_in&&rdy_out.
//           If accepted and !last_in, stay in ACCUM and clear first.
//           If accepted and last_in, register result into vec_out/divisor_out/sat_out,
//           go to DRAIN, set first=1, clear acc/l/sat.
//    DRAIN: rdy_out=0, vld_out=1; outputs held stable. On rdy_in, return to ACCUM next cycle.
//  - Throughput: one key step per cycle within a row; one bubble cycle per row for DRAIN.
//  - Latency: result visible (vld_out=1) the cycle after the last key step is accepted.
//  - Arithmetic per accepted step, for i in 0..VEC_LEN-1, on 2*DATA_WIDTH intermediates:
//    first=1: acc_n[i] = (p*v[i]) >>> FRAC_BITS;                           l_n = p
//    first=0: acc_n[i] = ((acc[i]*scale) >>> FRAC_BITS) + ((p*v[i]) >>> FRAC_BITS)
//             l_n = ((l*scale) >> FRAC_BITS) + p
//  - Shift and rounding:
//    - Shifts are arithmetic for signed terms and logical for unsigned terms.
//    - Rounding is floor (truncate toward -inf). No rounding offset is added.
//  - Saturation:
//    - acc_n saturates to the signed DATA_WIDTH range.
//    - l_n saturates to the unsigned max (2^DATA_WIDTH-1).
//    - Any clamp sets the sticky sat flag for the row.
//  - A single-key row (first=1 && last_in=1) is legal. Its result uses the first-key equations.
//  - vld_in while in DRAIN is not accepted; upstream holds its data.
//  - No internal check for a zero divisor. If p_in=0 for a whole row, divisor_out=0 is passed downstream.
// TESTING  (DATA_WIDTH=16, FRAC_BITS=8, 1.0=256; all lanes same value unless noted)
//  1 single-key row: p=256, v=512, last=1 -> next cycle vld_out=1, vec_out=512, divisor_out=256, sat_out=0
//  2 cancel: (p=128,v=256,scale=x) then (scale=256,p=128,v=-256,last) -> vec_out=0, divisor_out=256
//  3 rescale: (p=256,v=1024) then (scale=128,p=256,v=0,last) -> vec_out=512, divisor_out=384
//  4 backpressure: hold rdy_in=0 5 cycles in DRAIN with vld_in=1 -> vld_out=1, outputs stable,
//    rdy_out=0, no step consumed; rdy_in=1 -> ACCUM next cycle
//  5 saturation: (p=256,v=32767) then (scale=256,p=256,v=32767,last) -> vec_out=32767, sat_out=1;
//    the next row reports sat_out=0
//  6 reset mid-row: accept (p=256,v=100), pulse rst, then (p=256,v=7,last) -> vec_out=7,
//    divisor_out=256 (no residue from the pre-reset step)

Source files
------------

// File: rtl/output_row_accumulator_if.sv
// Key-step input bus and finished-row output bus of the online-softmax row accumulator.
// The accumulator uses the slave view; the upstream/downstream side uses the master view.
interface output_row_accumulator_if #(
  parameter int VEC_LEN    = 4,
  parameter int DATA_WIDTH = 16
);
  logic                                vld_in;
  logic                                rdy_out;
  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]  v_vec_in;
  logic [DATA_WIDTH-1:0]               p_in;
  logic [DATA_WIDTH-1:0]               scale_in;
  logic                                last_in;

  logic                                vld_out;
  logic                                rdy_in;
  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]  vec_out;
  logic [DATA_WIDTH-1:0]               divisor_out;
  logic                                sat_out;

  modport master (
    output vld_in, v_vec_in, p_in, scale_in, last_in, rdy_in,
    input  rdy_out, vld_out, vec_out, divisor_out, sat_out
  );

  modport slave (
    input  vld_in, v_vec_in, p_in, scale_in, last_in, rdy_in,
    output rdy_out, vld_out, vec_out, divisor_out, sat_out
  );
endinterface

// File: rtl/output_row_accumulator.sv
// Online-softmax output accumulator for one query row: rescales the running output vector and
// row-sum by the max-correction factor each key step, adds p*V, and hands (acc, l) to the divider.
module output_row_accumulator #(
  parameter int VEC_LEN    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output_row_accumulator_if.slave  bus
);

  // Two guard bits above 2*DATA_WIDTH keep zero-extended unsigned operands positive in signed math.
  localparam int PW = 2 * DATA_WIDTH + 2;

  typedef logic signed [PW-1:0]         wide_t;
  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  function automatic wide_t sext(input logic [DATA_WIDTH-1:0] x);
    return {{(PW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  endfunction

  function automatic wide_t zext(input logic [DATA_WIDTH-1:0] x);
    return {{(PW-DATA_WIDTH){1'b0}}, x};
  endfunction

  // Returns {clamped, value}: clamp to the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH:0] sat_signed(input wide_t x);
    wide_t hi;
    wide_t lo;
    hi = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    lo = ~hi;
    if (x > hi) begin
      return {1'b1, hi[DATA_WIDTH-1:0]};
    end else if (x < lo) begin
      return {1'b1, lo[DATA_WIDTH-1:0]};
    end
    return {1'b0, x[DATA_WIDTH-1:0]};
  endfunction

  // Returns {clamped, value}: clamp a non-negative value to the unsigned DATA_WIDTH range.
  function automatic logic [DATA_WIDTH:0] sat_unsigned(input wide_t x);
    wide_t umax;
    umax = {{(PW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
    if (x > umax) begin
      return {1'b1, {DATA_WIDTH{1'b1}}};
    end
    return {1'b0, x[DATA_WIDTH-1:0]};
  endfunction

  state_t                state_q, state_d;
  logic                  first_q;
  logic                  sat_q;
  elem_t                 acc_q [VEC_LEN];
  elem_t                 acc_d [VEC_LEN];
  logic [DATA_WIDTH-1:0] l_q, l_d;
  logic                  step_sat;
  logic                  accept;

  elem_t                 vec_q [VEC_LEN];
  logic [DATA_WIDTH-1:0] div_q;
  logic                  sat_out_q;

  always_comb begin
    state_d     = state_q;
    bus.rdy_out = 1'b0;
    bus.vld_out = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      ACCUM: begin
        bus.rdy_out = 1'b1;
        accept      = bus.vld_in;
        if (bus.vld_in && bus.last_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        bus.vld_out = 1'b1;
        if (bus.rdy_in) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Per-step update: floor shifts, first key ignores the old state and the scale factor.
  always_comb begin
    wide_t                 pv;
    wide_t                 rs;
    wide_t                 ls;
    logic [DATA_WIDTH:0]   s_acc;
    logic [DATA_WIDTH:0]   s_l;
    pv       = '0;
    rs       = '0;
    ls       = '0;
    s_acc    = '0;
    s_l      = '0;
    step_sat = 1'b0;
    for (int i = 0; i < VEC_LEN; i++) begin
      pv = (sext(bus.v_vec_in[i]) * zext(bus.p_in)) >>> FRAC_BITS;
      rs = '0;
      if (!first_q) begin
        rs = (sext(acc_q[i]) * zext(bus.scale_in)) >>> FRAC_BITS;
      end
      s_acc    = sat_signed(pv + rs);
      acc_d[i] = s_acc[DATA_WIDTH-1:0];
      step_sat = step_sat | s_acc[DATA_WIDTH];
    end
    if (first_q) begin
      ls = zext(bus.p_in);
    end else begin
      ls = ((zext(l_q) * zext(bus.scale_in)) >> FRAC_BITS) + zext(bus.p_in);
    end
    s_l      = sat_unsigned(ls);
    l_d      = s_l[DATA_WIDTH-1:0];
    step_sat = step_sat | s_l[DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      first_q   <= 1'b1;
      sat_q     <= 1'b0;
      l_q       <= '0;
      div_q     <= '0;
      sat_out_q <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) begin
        acc_q[i] <= '0;
        vec_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (bus.last_in) begin
          // Row complete: publish the result and restart the accumulator for the next row.
          div_q     <= l_d;
          sat_out_q <= sat_q | step_sat;
          first_q   <= 1'b1;
          sat_q     <= 1'b0;
          l_q       <= '0;
          for (int i = 0; i < VEC_LEN; i++) begin
            vec_q[i] <= acc_d[i];
            acc_q[i] <= '0;
          end
        end else begin
          first_q <= 1'b0;
          sat_q   <= sat_q | step_sat;
          l_q     <= l_d;
          for (int i = 0; i < VEC_LEN; i++) begin
            acc_q[i] <= acc_d[i];
          end
        end
      end
    end
  end

  always_comb begin
    bus.divisor_out = div_q;
    bus.sat_out     = sat_out_q;
    for (int i = 0; i < VEC_LEN; i++) begin
      bus.vec_out[i] = vec_q[i];
    end
  end

endmodule

// File: tb/tb_output_row_accumulator.sv
// Bench for output_row_accumulator: directed rows with known results plus randomized rows
// checked against an integer reference model of the online-softmax accumulation.
module tb_output_row_accumulator;
  localparam int VEC = 4;
  localparam int DW  = 16;
  localparam int FB  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_row_accumulator_if #(.VEC_LEN(VEC), .DATA_WIDTH(DW)) bus ();

  output_row_accumulator #(.VEC_LEN(VEC), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int     vin   [VEC];
  longint m_acc [VEC];
  longint m_l;
  bit     m_first;
  bit     m_sat;
  longint e_vec [VEC];
  longint e_l;
  bit     e_sat;

  function automatic longint fdiv(longint x);
    longint q;
    q = x / (64'sd1 << FB);
    if ((x % (64'sd1 << FB)) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(longint x, longint lo, longint hi, inout bit s);
    if (x > hi) begin s = 1'b1; return hi; end
    if (x < lo) begin s = 1'b1; return lo; end
    return x;
  endfunction

  function automatic void model_reset();
    m_first = 1'b1;
    m_sat   = 1'b0;
    m_l     = 0;
    for (int i = 0; i < VEC; i++) m_acc[i] = 0;
  endfunction

  function automatic void model_step(longint p, longint sc, bit last);
    longint nx [VEC];
    longint nl;
    for (int i = 0; i < VEC; i++) begin
      if (m_first) nx[i] = fdiv(p * vin[i]);
      else         nx[i] = fdiv(m_acc[i] * sc) + fdiv(p * vin[i]);
      nx[i] = clamp(nx[i], -32768, 32767, m_sat);
    end
    nl = m_first ? p : fdiv(m_l * sc) + p;
    nl = clamp(nl, 0, 65535, m_sat);
    if (last) begin
      for (int i = 0; i < VEC; i++) e_vec[i] = nx[i];
      e_l   = nl;
      e_sat = m_sat;
      model_reset();
    end else begin
      for (int i = 0; i < VEC; i++) m_acc[i] = nx[i];
      m_l     = nl;
      m_first = 1'b0;
    end
  endfunction

  task automatic set_all(int v);
    for (int i = 0; i < VEC; i++) vin[i] = v;
  endtask

  // Drives one key step at a falling edge; the DUT is expected to be in ACCUM.
  task automatic send_step(int p, int sc, bit last);
    bus.vld_in   = 1'b1;
    bus.p_in     = p[DW-1:0];
    bus.scale_in = sc[DW-1:0];
    bus.last_in  = last;
    for (int i = 0; i < VEC; i++) bus.v_vec_in[i] = DW'(vin[i]);
    model_step(p, sc, last);
    @(negedge clk);
    bus.vld_in  = 1'b0;
    bus.last_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++; if (bus.rdy_out !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", bus.rdy_out); end
    total++; if (bus.vld_out !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", bus.vld_out); end
    total++; if (bus.divisor_out !== 16'd0) begin bad++; $display("FAIL reset_div got=%0d want=0", bus.divisor_out); end
    total++; if (bus.sat_out !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", bus.sat_out); end
    for (int i = 0; i < VEC; i++) begin
      total++; if (bus.vec_out[i] !== 16'd0) begin bad++; $display("FAIL reset_vec[%0d] got=%0d want=0", i, bus.vec_out[i]); end
    end
  endtask

  task automatic test_single_key();
    set_all(512);
    send_step(256, 99, 1'b1);
    total++; if (bus.vld_out !== 1'b1) begin bad++; $display("FAIL single_vld got=%b want=1", bus.vld_out); end
    for (int i = 0; i < VEC; i++) begin
      total++; if (bus.vec_out[i] !== 16'd512) begin bad++; $display("FAIL single_vec[%0d] got=%0d want=512", i, bus.vec_out[i]); end
    end
    total++; if (bus.divisor_out !== 16'd256) begin bad++; $display("FAIL single_div got=%0d want=256", bus.divisor_out); end
    total++; if (bus.sat_out !== 1'b0) begin bad++; $display("FAIL single_sat got=%b want=0", bus.sat_out); end
    @(negedge clk);
    total++; if (bus.rdy_out !== 1'b1 || bus.vld_out !== 1'b0) begin bad++; $display("FAIL single_return rdy=%b vld=%b want rdy=1 vld=0", bus.rdy_out, bus.vld_out); end
  endtask

  task automatic test_cancel();
    set_all(256);  send_step(128, 77, 1'b0);
    set_all(-256); send_step(128, 256, 1'b1);
    for (int i = 0; i < VEC; i++) begin
      total++; if (bus.vec_out[i] !== 16'd0) begin bad++; $display("FAIL cancel_vec[%0d] got=%0d want=0", i, $signed(bus.vec_out[i])); end
    end
    total++; if (bus.divisor_out !== 16'd256) begin bad++; $display("FAIL cancel_div got=%0d want=256", bus.divisor_out); end
    @(negedge clk);
  endtask

  task automatic test_rescale();
    set_all(1024); send_step(256, 0, 1'b0);
    set_all(0);    send_step(256, 128, 1'b1);
    for (int i = 0; i < VEC; i++) begin
      total++; if (bus.vec_out[i] !== 16'd512) begin bad++; $display("FAIL rescale_vec[%0d] got=%0d want=512", i, bus.vec_out[i]); end
    end
    total++; if (bus.divisor_out !== 16'd384) begin bad++; $display("FAIL rescale_div got=%0d want=384", bus.divisor_out); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.rdy_in = 1'b0;
    set_all(3); send_step(256, 0, 1'b1);
    // Offer a non-last step while draining; accepting it would corrupt the following row.
    set_all(55);
    bus.vld_in = 1'b1; bus.p_in = 16'd999; bus.scale_in = 16'd256; bus.last_in = 1'b0;
    for (int i = 0; i < VEC; i++) bus.v_vec_in[i] = DW'(vin[i]);
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.vld_out !== 1'b1 || bus.rdy_out !== 1'b0) begin bad++; $display("FAIL bp_hs[%0d] vld=%b rdy=%b want vld=1 rdy=0", k, bus.vld_out, bus.rdy_out); end
      total++; if (bus.vec_out[k % VEC] !== 16'd3 || bus.divisor_out !== 16'd256) begin bad++; $display("FAIL bp_hold[%0d] vec=%0d div=%0d want 3/256", k, bus.vec_out[k % VEC], bus.divisor_out); end
      @(negedge clk);
    end
    bus.vld_in = 1'b0;
    bus.rdy_in = 1'b1;
    @(negedge clk);
    total++; if (bus.vld_out !== 1'b0 || bus.rdy_out !== 1'b1) begin bad++; $display("FAIL bp_release vld=%b rdy=%b want vld=0 rdy=1", bus.vld_out, bus.rdy_out); end
    set_all(9); send_step(256, 256, 1'b1);
    total++; if (bus.vec_out[0] !== 16'd9 || bus.divisor_out !== 16'd256) begin bad++; $display("FAIL bp_next vec=%0d div=%0d want 9/256", bus.vec_out[0], bus.divisor_out); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    set_all(32767); send_step(256, 0, 1'b0);
    send_step(256, 256, 1'b1);
    total++; if (bus.vec_out[VEC-1] !== 16'd32767) begin bad++; $display("FAIL sat_vec got=%0d want=32767", bus.vec_out[VEC-1]); end
    total++; if (bus.sat_out !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b want=1", bus.sat_out); end
    @(negedge clk);
    set_all(1); send_step(256, 0, 1'b1);
    total++; if (bus.sat_out !== 1'b0) begin bad++; $display("FAIL sat_next_flag got=%b want=0", bus.sat_out); end
    total++; if (bus.vec_out[0] !== 16'd1) begin bad++; $display("FAIL sat_next_vec got=%0d want=1", bus.vec_out[0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrow();
    set_all(100); send_step(256, 0, 1'b0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    model_reset();
    set_all(7); send_step(256, 256, 1'b1);
    total++; if (bus.vec_out[1] !== 16'd7) begin bad++; $display("FAIL rstmid_vec got=%0d want=7", bus.vec_out[1]); end
    total++; if (bus.divisor_out !== 16'd256) begin bad++; $display("FAIL rstmid_div got=%0d want=256", bus.divisor_out); end
    // Reset while the result is still pending downstream discards it.
    bus.rdy_in = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    total++; if (bus.vld_out !== 1'b0 || bus.divisor_out !== 16'd0) begin bad++; $display("FAIL rstdrain vld=%b div=%0d want 0/0", bus.vld_out, bus.divisor_out); end
    bus.rdy_in = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < VEC; i++) vin[i] = int'($urandom_range(0, 2000)) - 1000;
        send_step(int'($urandom_range(0, 400)), int'($urandom_range(0, 256)), k == 2);
      end
      total++; if (bus.vld_out !== 1'b1 || bus.divisor_out !== e_l[DW-1:0]) begin bad++; $display("FAIL b2b_row%0d vld=%b div=%0d want 1/%0d", r, bus.vld_out, bus.divisor_out, e_l); end
      for (int i = 0; i < VEC; i++) begin
        total++; if (bus.vec_out[i] !== e_vec[i][DW-1:0]) begin bad++; $display("FAIL b2b_vec r%0d[%0d] got=%0d want=%0d", r, i, $signed(bus.vec_out[i]), e_vec[i]); end
      end
      @(negedge clk);
      total++; if (bus.rdy_out !== 1'b1) begin bad++; $display("FAIL b2b_bubble r%0d rdy=%b want=1", r, bus.rdy_out); end
    end
  endtask

  task automatic test_random();
    int len, p, sc, hold;
    for (int r = 0; r < 40; r++) begin
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        for (int i = 0; i < VEC; i++) vin[i] = int'($signed(DW'($urandom)));
        p  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 512));
        sc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 256));
        send_step(p, sc, k == len - 1);
      end
      total++; if (bus.vld_out !== 1'b1) begin bad++; $display("FAIL rnd_vld r%0d got=%b want=1", r, bus.vld_out); end
      total++; if (bus.divisor_out !== e_l[DW-1:0]) begin bad++; $display("FAIL rnd_div r%0d got=%0d want=%0d", r, bus.divisor_out, e_l); end
      total++; if (bus.sat_out !== e_sat) begin bad++; $display("FAIL rnd_sat r%0d got=%b want=%b", r, bus.sat_out, e_sat); end
      for (int i = 0; i < VEC; i++) begin
        total++; if (bus.vec_out[i] !== e_vec[i][DW-1:0]) begin bad++; $display("FAIL rnd_vec r%0d[%0d] got=%0d want=%0d", r, i, $signed(bus.vec_out[i]), e_vec[i]); end
      end
      hold = int'($urandom_range(0, 2));
      bus.rdy_in = 1'b0;
      repeat (hold) @(negedge clk);
      bus.rdy_in = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.vld_in   = 1'b0;
    bus.last_in  = 1'b0;
    bus.rdy_in   = 1'b1;
    bus.p_in     = '0;
    bus.scale_in = '0;
    bus.v_vec_in = '0;
    rst          = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_key();
    test_cancel();
    test_rescale();
    test_backpressure();
    test_saturation();
    test_reset_midrow();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
